// File: rtl/traffic_phase_controller.sv
// Two-road + pedestrian intersection sequencer: phase FSM with a per-phase
// saturating down-counter, request latches and one-hot lamp decode.
module traffic_phase_controller #(
  parameter int BIT_WIDTH     = 7,
  parameter int MAIN_MIN_TIME = 20,
  parameter int YELLOW_TIME   = 4,
  parameter int ALLRED_TIME   = 2,
  parameter int SIDE_TIME     = 15,
  parameter int WALK_TIME     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sideSensor,
  input  logic                 pedReq,
  output logic [2:0]           mainLight,
  output logic [2:0]           sideLight,
  output logic                 walk,
  output logic [2:0]           state,
  output logic [BIT_WIDTH-1:0] timeLeft,
  output logic                 phaseDone
);

  typedef enum logic [2:0] {
    P_MG   = 3'd0,
    P_MY   = 3'd1,
    P_AR1  = 3'd2,
    P_WALK = 3'd3,
    P_SG   = 3'd4,
    P_SY   = 3'd5,
    P_AR2  = 3'd6
  } phase_e;

  localparam logic [BIT_WIDTH-1:0] MG_LOAD   = BIT_WIDTH'(MAIN_MIN_TIME - 1);
  localparam logic [BIT_WIDTH-1:0] Y_LOAD    = BIT_WIDTH'(YELLOW_TIME - 1);
  localparam logic [BIT_WIDTH-1:0] AR_LOAD   = BIT_WIDTH'(ALLRED_TIME - 1);
  localparam logic [BIT_WIDTH-1:0] SG_LOAD   = BIT_WIDTH'(SIDE_TIME - 1);
  localparam logic [BIT_WIDTH-1:0] WALK_LOAD = BIT_WIDTH'(WALK_TIME - 1);

  phase_e               state_q, state_d;
  logic [BIT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 side_latch_q, side_latch_d;
  logic                 ped_latch_q, ped_latch_d;
  logic                 side_pend, ped_pend, done;

  assign side_pend = side_latch_q | sideSensor;
  assign ped_pend  = ped_latch_q | pedReq;
  assign done      = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = done ? cnt_q : cnt_q - BIT_WIDTH'(1);
    case (state_q)
      P_MG: if (done && (side_pend || ped_pend)) begin
        state_d = P_MY; cnt_d = Y_LOAD;
      end
      P_MY: if (done) begin
        state_d = P_AR1; cnt_d = AR_LOAD;
      end
      P_AR1: if (done) begin
        if (ped_pend)       begin state_d = P_WALK; cnt_d = WALK_LOAD; end
        else if (side_pend) begin state_d = P_SG;   cnt_d = SG_LOAD;   end
        else                begin state_d = P_MG;   cnt_d = MG_LOAD;   end
      end
      P_WALK: if (done) begin
        if (side_pend) begin state_d = P_SG; cnt_d = SG_LOAD; end
        else           begin state_d = P_MG; cnt_d = MG_LOAD; end
      end
      P_SG: if (done) begin
        state_d = P_SY; cnt_d = Y_LOAD;
      end
      P_SY: if (done) begin
        state_d = P_AR2; cnt_d = AR_LOAD;
      end
      P_AR2: if (done) begin
        state_d = P_MG; cnt_d = MG_LOAD;
      end
      // Unused code 7 recovers straight to a fresh main-green.
      default: begin
        state_d = P_MG; cnt_d = MG_LOAD;
      end
    endcase
  end

  // Clear on the entering edge overrides a coincident set.
  assign side_latch_d = (state_d == P_SG && state_q != P_SG) ? 1'b0 : side_pend;
  assign ped_latch_d  = (state_d == P_WALK && state_q != P_WALK) ? 1'b0 : ped_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= P_MG;
      cnt_q        <= MG_LOAD;
      side_latch_q <= 1'b0;
      ped_latch_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      side_latch_q <= side_latch_d;
      ped_latch_q  <= ped_latch_d;
    end
  end

  always_comb begin
    mainLight = 3'b100;
    sideLight = 3'b100;
    walk      = 1'b0;
    case (state_q)
      P_MG:    mainLight = 3'b001;
      P_MY:    mainLight = 3'b010;
      P_WALK:  walk      = 1'b1;
      P_SG:    sideLight = 3'b001;
      P_SY:    sideLight = 3'b010;
      default: ;
    endcase
  end

  assign state     = state_q;
  assign timeLeft  = cnt_q;
  assign phaseDone = done;

endmodule

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

Sequences a two-road intersection (main road, side road) plus a pedestrian crossing through a fixed cycle of light phases. Runs an internal saturating down-counter per phase. Latches side-road car and pedestrian requests. Decodes one-hot lamp outputs for both roads and the walk signal. Sits above the countdown timer datapath as its sequencer and is the top-level control block of the traffic light design.

## Interface
- BIT_WIDTH, 7, width of the phase counter and of `timeLeft`.
- MAIN_MIN_TIME, 20, minimum main-green duration in cycles.
- YELLOW_TIME, 4, yellow duration for either road, in cycles.
- ALLRED_TIME, 2, all-red clearance duration in cycles.
- SIDE_TIME, 15, side-green duration in cycles.
- WALK_TIME, 10, pedestrian walk duration in cycles.
- Constraint on every *_TIME: 1 ≤ N ≤ 2^BIT_WIDTH.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, synchronous, active-high reset.
- sideSensor, input, 1, side-road car present; level or pulse.
- pedReq, input, 1, pedestrian button; level or pulse.
- mainLight, output, 3, {red, yellow, green}, one-hot.
- sideLight, output, 3, {red, yellow, green}, one-hot.
- walk, output, 1, pedestrian walk lamp.
- state, output, 3, current phase code.
- timeLeft, output, BIT_WIDTH, current phase counter value.
- phaseDone, output, 1, high when `timeLeft == 0`.

## Operation
Phase codes and lamp decode:
- MG=0: main 001, side 100, walk 0.
- MY=1: main 010, side 100, walk 0.
- AR1=2: main 100, side 100, walk 0.
- WALK=3: main 100, side 100, walk 1.
- SG=4: main 100, side 001, walk 0.
- SY=5: main 100, side 010, walk 0.
- AR2=6: main 100, side 100, walk 0.
- Code 7 is illegal; it must transition to MG with count MAIN_MIN_TIME-1.

Counter:
- On entry to a phase with duration N, load N-1.
- Decrement each cycle while nonzero.
- Saturate at 0; never wrap.

Requests:
- `sideLatch` is set by `sideSensor`; `pedLatch` is set by `pedReq`.
- `sidePend = sideLatch | sideSensor`; `pedPend = pedLatch | pedReq`.
- `sideLatch` is cleared on the cycle the FSM enters SG. `pedLatch` is cleared on the cycle it enters WALK.
- If set and clear coincide, clear wins.
- The latches accept sets during any phase.

Transitions (taken only when `timeLeft == 0`):
- MG → MY if `sidePend | pedPend`; otherwise hold MG at count 0 indefinitely.
- MY → AR1.
- AR1 → WALK if `pedPend`; else SG if `sidePend`; else MG.
- WALK → SG if `sidePend`; else MG.
- SG → SY → AR2 → MG.

Reset and invariants:
- rst takes effect on the next edge from any phase, including mid-phase.
- Reset values: state MG, `timeLeft` = MAIN_MIN_TIME-1, both latches 0.
- Outputs after reset: mainLight 001, sideLight 100, walk 0, phaseDone 1 only if MAIN_MIN_TIME=1.
- The two roads are never both non-red.

## Timing
- All outputs are combinational decodes of registered state and counter; no extra latency.
- A phase of duration N is visible for exactly N cycles, except MG, which lasts ≥ MAIN_MIN_TIME.
- A request asserted on the last MG cycle (count 0) is honoured that cycle: MY begins on the next cycle.
- A request asserted during MG before count 0 is latched; MG still completes its minimum time.
- Cycle 0 is defined as the first cycle after rst deasserts.

## Test plan
Params for all scenarios: MAIN_MIN=4, YELLOW=2, ALLRED=1, SIDE=3, WALK=2.

- No requests after reset → state 0; timeLeft 3,2,1,0,0,0…; mainLight 001, sideLight 100 indefinitely; phaseDone from cycle 3.
- sideSensor pulse at cycle 1 → MG cycles 0–3, MY 4–5, AR1 6, SG 7–9 (sideLight 001), SY 10–11, AR2 12, MG at 13 with timeLeft 3.
- pedReq pulse at cycle 2 only → MG 0–3, MY 4–5, AR1 6, WALK 7–8 (walk=1), MG at 9; SG never entered.
- sideSensor and pedReq both pulsed at cycle 0 → MG 0–3, MY 4–5, AR1 6, WALK 7–8, SG 9–11, SY 12–13, AR2 14, MG 15.
- sideSensor held high from cycle 0 → first SG 7–9; latch re-sets during SG; MG 13–16; MY at 17; the clear at SG entry must not lose later sets.
- rst asserted for one cycle while in SG (cycle 8) → cycle 9 shows state 0, timeLeft 3, walk 0; with no further requests, state stays MG.
